gpr_wb_arbiter: RTL and testbench

//  Shares the single write port of the 8x16 general purpose register file between two

---
 rtl/gpr_wb_arbiter.sv | 93 +++++++++
 tb/tb_gpr_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin share of the GPR write port between ALU (A)
// and load unit (B), with a registered write port and a per-register busy
// scoreboard for decode RAW stalls.
// Ports: clk, rst_n (async, active low); a_valid/a_ready/a_dest/a_data and
// b_valid/b_ready/b_dest/b_data writeback requests; iss_en/iss_dest from
// decode; gpr_we/gpr_dest/gpr_data to the register file; busy[NREG-1:0]
// pending-write flags; last_grant (0 = A granted last, 1 = B).
module gpr_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              gpr_we,
  output logic [ADDR_W-1:0] gpr_dest,
  output logic [DATA_W-1:0] gpr_data,
  output logic [NREG-1:0]   busy,
  output logic              last_grant
);

  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_nxt;

  // On a tie, the side that did not win last time gets the port.
  always_comb begin
    grant_a = a_valid & (~b_valid | last_grant);
    grant_b = b_valid & (~a_valid | ~last_grant);
    grant   = grant_a | grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    sel_dest = a_dest;
    sel_data = a_data;
    unique case (1'b1)
      grant_b: begin
        sel_dest = b_dest;
        sel_data = b_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_we     <= 1'b0;
      gpr_dest   <= '0;
      gpr_data   <= '0;
      last_grant <= 1'b0;
    end else if (grant) begin
      // r0 is hardwired zero: accept the request but never write it.
      gpr_we     <= (sel_dest != '0);
      gpr_dest   <= sel_dest;
      gpr_data   <= sel_data;
      last_grant <= grant_b;
    end else begin
      gpr_we     <= 1'b0;
    end
  end

  // Set beats clear: a same-cycle issue means a younger writer is pending.
  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_nxt[i] =
        (iss_en & (iss_dest == ADDR_W'(i))) |
        (busy[i] & ~(gpr_we & (gpr_dest == ADDR_W'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed bench for gpr_wb_arbiter.
// Linear stimulus with hand-computed expectations checked by assertions.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_en;
  logic        a_ready, b_ready;
  logic [2:0]  a_dest, b_dest, iss_dest;
  logic [15:0] a_data, b_data;
  logic        gpr_we;
  logic [2:0]  gpr_dest;
  logic [15:0] gpr_data;
  logic [7:0]  busy;
  logic        last_grant;

  int tests = 0;
  int fails = 0;

  gpr_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_dest     (a_dest),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_dest     (b_dest),
    .b_data     (b_data),
    .iss_en     (iss_en),
    .iss_dest   (iss_dest),
    .gpr_we     (gpr_we),
    .gpr_dest   (gpr_dest),
    .gpr_data   (gpr_data),
    .busy       (busy),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_b;
    logic [15:0] exp_d;
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; iss_en = 0;
    a_dest = 0; b_dest = 0; iss_dest = 0;
    a_data = 0; b_data = 0;
    tick();
    tick();
    chk("rst_we", gpr_we, 0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_lg", last_grant, 0);
    rst_n = 1'b1;

    // put state in flight: B writes r4, r4 issued
    b_valid = 1; b_dest = 4; b_data = 16'h0044;
    iss_en = 1; iss_dest = 4;
    tick();
    chk("pre_we", gpr_we, 1);
    chk("pre_lg", last_grant, 1);
    chk("pre_busy", busy, 8'h10);
    b_valid = 0; iss_en = 0;
    a_valid = 1; a_dest = 3; a_data = 16'hBEEF;
    #2;
    // async reset mid-cycle, no clock edge
    rst_n = 1'b0;
    #1;
    chk("arst_we", gpr_we, 0);
    chk("arst_busy", busy, 8'h00);
    chk("arst_lg", last_grant, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_a_ready", a_ready, 1);
    chk("rel_b_ready", b_ready, 0);

    // single A write
    tick();
    chk("a_we", gpr_we, 1);
    chk("a_dest", gpr_dest, 3);
    chk("a_data", gpr_data, 16'hBEEF);
    a_valid = 0;
    #1;
    chk("a_ready_lo", a_ready, 0);
    tick();
    chk("a_we_lo", gpr_we, 0);
    chk("a_dest_hold", gpr_dest, 3);
    chk("a_data_hold", gpr_data, 16'hBEEF);
    chk("a_lg", last_grant, 0);

    // first tie goes to B
    a_valid = 1; a_dest = 1; a_data = 16'h0011;
    b_valid = 1; b_dest = 2; b_data = 16'h0022;
    #1;
    chk("tie_b_ready", b_ready, 1);
    chk("tie_a_ready", a_ready, 0);
    tick();
    chk("tie1_we", gpr_we, 1);
    chk("tie1_dest", gpr_dest, 2);
    chk("tie1_data", gpr_data, 16'h0022);
    chk("tie1_lg", last_grant, 1);
    b_valid = 0;
    #1;
    chk("tie2_a_ready", a_ready, 1);
    tick();
    chk("tie2_dest", gpr_dest, 1);
    chk("tie2_data", gpr_data, 16'h0011);
    chk("tie2_lg", last_grant, 0);
    a_valid = 0;
    tick();
    chk("tie_idle_we", gpr_we, 0);

    // continuous contention: B,A,B,A,B,A
    a_valid = 1; a_dest = 6; a_data = 16'hA000;
    b_valid = 1; b_dest = 7; b_data = 16'hB000;
    for (int k = 0; k < 6; k++) begin
      exp_b = (k % 2 == 0);
      exp_d = exp_b ? 16'hB000 + 16'(k / 2)
                    : 16'hA000 + 16'(k / 2);
      #1;
      chk("cont_b_ready", b_ready, exp_b);
      chk("cont_a_ready", a_ready, !exp_b);
      tick();
      chk("cont_we", gpr_we, 1);
      chk("cont_dest", gpr_dest, exp_b ? 7 : 6);
      chk("cont_data", gpr_data, exp_d);
      chk("cont_lg", last_grant, exp_b);
      if (exp_b) b_data = b_data + 16'd1;
      else       a_data = a_data + 16'd1;
    end
    a_valid = 0; b_valid = 0;
    tick();
    chk("cont_idle_we", gpr_we, 0);

    // scoreboard set / clear at commit edge
    iss_en = 1; iss_dest = 5;
    tick();
    iss_en = 0;
    chk("sb_set", busy, 8'h20);
    a_valid = 1; a_dest = 5; a_data = 16'h5555;
    tick();
    a_valid = 0;
    chk("sb_wr_we", gpr_we, 1);
    chk("sb_wr_dest", gpr_dest, 5);
    chk("sb_still_busy", busy, 8'h20);
    tick();
    chk("sb_clear", busy, 8'h00);
    chk("sb_we_lo", gpr_we, 0);

    // same-cycle set and clear: set wins
    iss_en = 1; iss_dest = 5;
    tick();
    iss_en = 0;
    a_valid = 1; a_dest = 5; a_data = 16'h5656;
    tick();
    a_valid = 0;
    chk("sw_we", gpr_we, 1);
    iss_en = 1; iss_dest = 5;
    tick();
    iss_en = 0;
    chk("sw_set_wins", busy, 8'h20);
    a_valid = 1; a_dest = 5; a_data = 16'h5757;
    tick();
    a_valid = 0;
    tick();
    chk("sw_release", busy, 8'h00);

    // writes to r0 are accepted and dropped
    b_valid = 1; b_dest = 0; b_data = 16'hDEAD;
    iss_en = 1; iss_dest = 0;
    #1;
    chk("r0_b_ready", b_ready, 1);
    tick();
    b_valid = 0; iss_en = 0;
    chk("r0_we", gpr_we, 0);
    chk("r0_busy", busy, 8'h00);
    chk("r0_lg", last_grant, 1);
    tick();
    chk("r0_we2", gpr_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
